// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the KGP-RISC fetch stage.
// Sequential increment by STEP, branch, pipeline stall and, when the
// PC_RAS_EN macro is defined, call/return through a circular
// return-address stack of RAS_DEPTH entries (power of two, >= 2).
// Without PC_RAS_EN no stack is built: call acts as branch, ret is ignored.
module pc_sequencer #(
  parameter int               WIDTH     = 32,
  parameter int               STEP      = 1,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_udf
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pc_plus;

  assign w_pc_plus = r_pc + WIDTH'(STEP);
  assign pc        = r_pc;
  assign pc_plus   = w_pc_plus;

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  // r_ptr is the next free slot; the top entry sits one below it (mod depth).
  // When full, r_ptr also addresses the oldest entry, so a push there
  // overwrites it naturally.
  logic [WIDTH-1:0] r_stack [RAS_DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_udf;
  logic [PW-1:0]    w_top_idx;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_repl;
  logic             w_udf_set;

  assign w_top_idx = r_ptr - PW'(1);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == DEPTH_C);
  assign ras_top   = w_empty ? '0 : r_stack[w_top_idx];
  assign ras_empty = w_empty;
  assign ras_full  = w_full;
  assign ras_ovf   = r_ovf;
  assign ras_udf   = r_udf;

  // Next-PC and stack-operation decode: (call&ret) > ret > call > branch > increment.
  always_comb begin
    w_pc_nxt  = w_pc_plus;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_repl    = 1'b0;
    w_udf_set = 1'b0;
    if (call && ret && !w_empty) begin
      w_pc_nxt = target;
      w_repl   = 1'b1;
    end else if (ret && !call) begin
      if (!w_empty) begin
        w_pc_nxt = ras_top;
        w_pop    = 1'b1;
      end else begin
        w_udf_set = 1'b1;
      end
    end else if (call) begin
      // Covers call&ret on an empty stack: a plain call, no underflow.
      w_pc_nxt = target;
      w_push   = 1'b1;
    end else if (branch) begin
      w_pc_nxt = target;
    end
  end

  // Stack pointer, occupancy count and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (!stall) begin
      if (w_push) begin
        r_ptr <= r_ptr + PW'(1);
        if (w_full) r_ovf <= 1'b1;
        else        r_cnt <= r_cnt + CW'(1);
      end else if (w_pop) begin
        r_ptr <= r_ptr - PW'(1);
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_udf_set) r_udf <= 1'b1;
    end
  end

  // Stack storage: push writes the free slot, call&ret rewrites the top.
  always_ff @(posedge clk) begin
    if (!reset && !stall) begin
      if (w_push)      r_stack[r_ptr]     <= w_pc_plus;
      else if (w_repl) r_stack[w_top_idx] <= w_pc_plus;
    end
  end
`else
  logic w_unused_ret;

  assign w_unused_ret = ret;
  assign ras_top      = '0;
  assign ras_empty    = 1'b1;
  assign ras_full     = 1'b0;
  assign ras_ovf      = 1'b0;
  assign ras_udf      = 1'b0;

  // Next-PC decode without a stack: call is a branch, ret is ignored.
  always_comb begin
    w_pc_nxt = w_pc_plus;
    if (branch || call) w_pc_nxt = target;
  end
`endif

  // Program counter register; stall holds it.
  always_ff @(posedge clk) begin
    if (reset)       r_pc <= RESET_VEC;
    else if (!stall) r_pc <= w_pc_nxt;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with STEP=4, RESET_VEC=0x100, RAS_DEPTH=4.
// A shared vector table covers reset, increment, wrap, stall and branch;
// hand-written sequences cover call/ret (PC_RAS_EN) or the stackless build.
module tb_pc_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         stall = 1'b0;
  logic         branch = 1'b0;
  logic         call = 1'b0;
  logic         ret = 1'b0;
  logic [W-1:0] target = '0;
  logic [W-1:0] pc, pc_plus, ras_top;
  logic         ras_empty, ras_full, ras_ovf, ras_udf;

  int n_total = 0;
  int n_pass  = 0;

  pc_sequencer #(
    .WIDTH(W), .STEP(4), .RESET_VEC(32'h100), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .call(call),
    .ret(ret), .target(target), .pc(pc), .pc_plus(pc_plus), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf),
    .ras_udf(ras_udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rs, st, br, ca, re;
    logic [W-1:0] tg;
    logic [W-1:0] e_pc, e_top;
    logic         e_emp, e_full, e_ovf, e_udf;
  } vec_t;

  function automatic void chk(input string name, input logic [W-1:0] act,
                              input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Drive one cycle of inputs at negedge, check all outputs 1 ns after posedge.
  task automatic step(input vec_t v);
    @(negedge clk);
    reset = v.rs; stall = v.st; branch = v.br; call = v.ca; ret = v.re;
    target = v.tg;
    @(posedge clk);
    #1;
    chk({v.name, ".pc"},      pc,      v.e_pc);
    chk({v.name, ".pc_plus"}, pc_plus, v.e_pc + 32'd4);
    chk({v.name, ".top"},     ras_top, v.e_top);
    chk({v.name, ".empty"},   {31'd0, ras_empty}, {31'd0, v.e_emp});
    chk({v.name, ".full"},    {31'd0, ras_full},  {31'd0, v.e_full});
    chk({v.name, ".ovf"},     {31'd0, ras_ovf},   {31'd0, v.e_ovf});
    chk({v.name, ".udf"},     {31'd0, ras_udf},   {31'd0, v.e_udf});
  endtask

  // Shorthand: vector with a given stack state.
  function automatic vec_t mk(input string n, input logic rs, st, br, ca, re,
                              input logic [W-1:0] tg, e_pc, e_top,
                              input logic e_emp, e_full, e_ovf, e_udf);
    vec_t v;
    v.name = n; v.rs = rs; v.st = st; v.br = br; v.ca = ca; v.re = re;
    v.tg = tg; v.e_pc = e_pc; v.e_top = e_top;
    v.e_emp = e_emp; v.e_full = e_full; v.e_ovf = e_ovf; v.e_udf = e_udf;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    //              name        rs st br ca re target        pc            top  emp full ovf udf
    tbl.push_back(mk("reset",    1, 0, 0, 0, 0, 32'h0,        32'h100,      0,   1, 0, 0, 0));
    tbl.push_back(mk("inc1",     0, 0, 0, 0, 0, 32'h0,        32'h104,      0,   1, 0, 0, 0));
    tbl.push_back(mk("inc2",     0, 0, 0, 0, 0, 32'h0,        32'h108,      0,   1, 0, 0, 0));
    tbl.push_back(mk("inc3",     0, 0, 0, 0, 0, 32'h0,        32'h10C,      0,   1, 0, 0, 0));
    tbl.push_back(mk("br_top",   0, 0, 1, 0, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 0,   1, 0, 0, 0));
    tbl.push_back(mk("wrap",     0, 0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 0, 0, 0));
    tbl.push_back(mk("stall1",   0, 1, 1, 0, 0, 32'h40,       32'h0,        0,   1, 0, 0, 0));
    tbl.push_back(mk("stall2",   0, 1, 1, 0, 0, 32'h40,       32'h0,        0,   1, 0, 0, 0));
    tbl.push_back(mk("unstall",  0, 0, 0, 0, 0, 32'h40,       32'h4,        0,   1, 0, 0, 0));
    tbl.push_back(mk("rst_stl",  1, 1, 1, 0, 0, 32'h40,       32'h100,      0,   1, 0, 0, 0));
    tbl.push_back(mk("br10",     0, 0, 1, 0, 0, 32'h10,       32'h10,       0,   1, 0, 0, 0));
    foreach (tbl[i]) step(tbl[i]);

`ifdef PC_RAS_EN
    // Nested call / return from pc=0x10.
    step(mk("call80",   0, 0, 0, 1, 0, 32'h80,   32'h80,   32'h14,   0, 0, 0, 0));
    step(mk("inc84",    0, 0, 0, 0, 0, 32'h0,    32'h84,   32'h14,   0, 0, 0, 0));
    step(mk("callC0",   0, 0, 0, 1, 0, 32'hC0,   32'hC0,   32'h88,   0, 0, 0, 0));
    step(mk("stl_call", 0, 1, 0, 1, 0, 32'h300,  32'hC0,   32'h88,   0, 0, 0, 0));
    step(mk("ret88",    0, 0, 0, 0, 1, 32'h0,    32'h88,   32'h14,   0, 0, 0, 0));
    step(mk("ret14",    0, 0, 0, 0, 1, 32'h0,    32'h14,   32'h0,    1, 0, 0, 0));

    // Overflow: five calls into a 4-deep stack, then five returns.
    step(mk("rst_b",    1, 0, 0, 0, 0, 32'h0,    32'h100,  32'h0,    1, 0, 0, 0));
    step(mk("callA",    0, 0, 0, 1, 0, 32'h1000, 32'h1000, 32'h104,  0, 0, 0, 0));
    step(mk("callB",    0, 0, 1, 1, 0, 32'h2000, 32'h2000, 32'h1004, 0, 0, 0, 0));
    step(mk("callC",    0, 0, 0, 1, 0, 32'h3000, 32'h3000, 32'h2004, 0, 0, 0, 0));
    step(mk("callD",    0, 0, 0, 1, 0, 32'h4000, 32'h4000, 32'h3004, 0, 1, 0, 0));
    step(mk("callE",    0, 0, 0, 1, 0, 32'h5000, 32'h5000, 32'h4004, 0, 1, 1, 0));
    step(mk("retE",     0, 0, 0, 0, 1, 32'h0,    32'h4004, 32'h3004, 0, 0, 1, 0));
    step(mk("retD",     0, 0, 0, 0, 1, 32'h0,    32'h3004, 32'h2004, 0, 0, 1, 0));
    step(mk("retC",     0, 0, 0, 0, 1, 32'h0,    32'h2004, 32'h1004, 0, 0, 1, 0));
    step(mk("retB",     0, 0, 0, 0, 1, 32'h0,    32'h1004, 32'h0,    1, 0, 1, 0));
    step(mk("ret_udf",  0, 0, 0, 0, 1, 32'h0,    32'h1008, 32'h0,    1, 0, 1, 1));
    step(mk("rst_flag", 1, 0, 0, 0, 0, 32'h0,    32'h100,  32'h0,    1, 0, 0, 0));

    // call & ret together: replace top when non-empty, plain call when empty.
    step(mk("br1C",     0, 0, 1, 0, 0, 32'h1C,   32'h1C,   32'h0,    1, 0, 0, 0));
    step(mk("call50",   0, 0, 0, 1, 0, 32'h50,   32'h50,   32'h20,   0, 0, 0, 0));
    step(mk("callret",  0, 0, 0, 1, 1, 32'h200,  32'h200,  32'h54,   0, 0, 0, 0));
    step(mk("ret54",    0, 0, 0, 0, 1, 32'h0,    32'h54,   32'h0,    1, 0, 0, 0));
    step(mk("cr_empty", 0, 0, 0, 1, 1, 32'h300,  32'h300,  32'h58,   0, 0, 0, 0));
    step(mk("ret58",    0, 0, 0, 0, 1, 32'h0,    32'h58,   32'h0,    1, 0, 0, 0));
`else
    // Stackless build: call is a branch, ret is ignored, ras_* constant.
    step(mk("call30",   0, 0, 0, 1, 0, 32'h30,   32'h30,   32'h0,    1, 0, 0, 0));
    step(mk("ret_ign",  0, 0, 0, 0, 1, 32'h0,    32'h34,   32'h0,    1, 0, 0, 0));
    step(mk("callret",  0, 0, 0, 1, 1, 32'h200,  32'h200,  32'h0,    1, 0, 0, 0));
    step(mk("stl_ret",  0, 1, 0, 0, 1, 32'h0,    32'h200,  32'h0,    1, 0, 0, 0));
    step(mk("ret_ign2", 0, 0, 0, 0, 1, 32'h0,    32'h204,  32'h0,    1, 0, 0, 0));
`endif

    @(negedge clk);
    reset = 1'b0; stall = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
